// File: rtl/serial_pkg.sv
// Shared constants and state type for the serial transmit shifter.
package serial_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/serial_tx_shifter.sv
// Parallel-to-serial shifter with a one-word hold buffer; first bit one cycle after acceptance.
// Backpressure: load_ready drops only while the hold buffer is occupied; frames run back-to-back.
module serial_tx_shifter
    import serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             msb_first,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             shmsb_q, shmsb_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_msb_q, hold_msb_d;
    logic             hold_full_q, hold_full_d;

    logic          accept;
    logic          free;
    logic [CW-1:0] bit_idx;

    assign load_ready = ~hold_full_q;
    assign accept     = load_valid & ~hold_full_q;
    assign free       = (state_q == IDLE) || (cnt_q == LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        shmsb_d     = shmsb_q;
        hold_d      = hold_q;
        hold_msb_d  = hold_msb_q;
        hold_full_d = hold_full_q;

        if (free) begin
            // A held word always has priority; an accept cannot coincide with a full hold buffer.
            if (hold_full_q) begin
                shreg_d     = hold_q;
                shmsb_d     = hold_msb_q;
                state_d     = SHIFT;
                cnt_d       = '0;
                hold_full_d = 1'b0;
            end else if (accept) begin
                shreg_d = parallel_in;
                shmsb_d = msb_first;
                state_d = SHIFT;
                cnt_d   = '0;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (accept) begin
                hold_d      = parallel_in;
                hold_msb_d  = msb_first;
                hold_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            shmsb_q     <= 1'b0;
            hold_q      <= '0;
            hold_msb_q  <= 1'b0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            shmsb_q     <= shmsb_d;
            hold_q      <= hold_d;
            hold_msb_q  <= hold_msb_d;
            hold_full_q <= hold_full_d;
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    assign bit_idx      = shmsb_q ? (LAST - cnt_q) : cnt_q;
    assign serial_valid = (state_q == SHIFT);
    assign serial_out   = (state_q == SHIFT) ? shreg_q[bit_idx] : 1'b0;
    assign frame_done   = (state_q == SHIFT) && (cnt_q == LAST);
    assign busy         = (state_q == SHIFT) || hold_full_q;

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Directed and randomized bench for serial_tx_shifter against a frame-queue reference model.
module tb_serial_tx_shifter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] parallel_in = '0;
    logic         load_valid = 1'b0;
    logic         msb_first = 1'b0;
    logic         load_ready;
    logic         serial_out;
    logic         serial_valid;
    logic         frame_done;
    logic         busy;

    serial_tx_shifter #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .parallel_in  (parallel_in),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .msb_first    (msb_first),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] w;
        logic         m;
    } frm_t;

    int   compared = 0;
    int   mismatched = 0;

    // Reference: the frame being sent (pos = bit position, -1 when nothing is on the line)
    // plus the words accepted but not yet started.
    frm_t cur;
    int   pos = -1;
    frm_t pend[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit();
        if (pos < 0) return 1'b0;
        return cur.m ? cur.w[W-1-pos] : cur.w[pos];
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, 32'(serial_valid), 32'(pos >= 0));
        chk({tag, ".out"},   32'(serial_out),   32'(exp_bit()));
        chk({tag, ".done"},  32'(frame_done),   32'(pos == W-1));
        chk({tag, ".busy"},  32'(busy),         32'((pos >= 0) || (pend.size() > 0)));
        chk({tag, ".ready"}, 32'(load_ready),   32'(pend.size() == 0));
    endtask

    // Entered and left at posedge+1: drive, take one edge, advance the model, compare.
    task automatic step(input logic v, input logic [W-1:0] w, input logic m, input string tag);
        frm_t nf;
        logic acc;
        load_valid  = v;
        parallel_in = w;
        msb_first   = m;
        acc = v && (pend.size() == 0);
        nf.w = w;
        nf.m = m;
        @(posedge clk);
        if (pos < 0 || pos == W-1) begin
            if (pend.size() > 0) begin
                cur = pend.pop_front();
                pos = 0;
                if (acc) pend.push_back(nf);
            end else if (acc) begin
                cur = nf;
                pos = 0;
            end else begin
                pos = -1;
            end
        end else begin
            pos++;
            if (acc) pend.push_back(nf);
        end
        #1;
        // Scramble inputs so any late sampling of them would show up.
        parallel_in = W'($urandom);
        msb_first   = 1'($urandom);
        check_model(tag);
    endtask

    logic [W-1:0] seq;
    logic         sv_log[20];
    logic         fd_log[20];
    int           sv_cnt;
    int           fd_cnt;
    int           fd_first;
    int           fd_last;

    initial begin
        // Reset state, asynchronous: checked before any clock edge.
        #2;
        chk("rst.valid", 32'(serial_valid), 32'd0);
        chk("rst.busy",  32'(busy),         32'd0);
        chk("rst.ready", 32'(load_ready),   32'd1);
        chk("rst.out",   32'(serial_out),   32'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: 8'hC1 LSB first.
        seq = 8'b1100_0001;
        step(1'b1, 8'hC1, 1'b0, "t1");
        for (int i = 0; i < W; i++) begin
            chk("t1.bit",  32'(serial_out), 32'(seq[i]));
            chk("t1.done", 32'(frame_done), 32'(i == W-1));
            step(1'b0, '0, 1'b0, "t1");
        end
        chk("t1.idle", 32'(serial_valid), 32'd0);

        // Test 2: 8'hC1 MSB first.
        seq = 8'b1000_0011;
        step(1'b1, 8'hC1, 1'b1, "t2");
        for (int i = 0; i < W; i++) begin
            chk("t2.bit", 32'(serial_out), 32'(seq[i]));
            step(1'b0, '0, 1'b0, "t2");
        end

        // Test 3: two words offered back-to-back.
        step(1'b1, 8'h12, 1'b0, "t3");
        sv_log[0] = serial_valid;
        fd_log[0] = frame_done;
        step(1'b1, 8'h34, 1'b0, "t3");
        sv_log[1] = serial_valid;
        fd_log[1] = frame_done;
        for (int k = 2; k < 20; k++) begin
            if (k <= 7) chk("t3.held_ready", 32'(load_ready), 32'd0);
            step(1'b0, '0, 1'b0, "t3");
            sv_log[k] = serial_valid;
            fd_log[k] = frame_done;
        end
        sv_cnt = 0;
        fd_cnt = 0;
        fd_first = -1;
        fd_last = -1;
        for (int k = 0; k < 20; k++) begin
            if (sv_log[k] && k < 16) sv_cnt++;
            if (fd_log[k]) begin
                fd_cnt++;
                if (fd_first < 0) fd_first = k;
                fd_last = k;
            end
        end
        chk("t3.contig",  32'(sv_cnt),           32'd16);
        chk("t3.gap_end", 32'(sv_log[16]),       32'd0);
        chk("t3.ndone",   32'(fd_cnt),           32'd2);
        chk("t3.spacing", 32'(fd_last - fd_first), 32'd8);

        // Test 4: accept on the edge that ends the last bit, hold buffer empty.
        step(1'b1, 8'hA5, 1'b0, "t4");
        for (int i = 0; i < W-1; i++) step(1'b0, '0, 1'b0, "t4");
        chk("t4.lastbit", 32'(frame_done), 32'd1);
        step(1'b1, 8'h3C, 1'b1, "t4");
        chk("t4.nogap", 32'(serial_valid), 32'd1);
        chk("t4.bit0",  32'(serial_out),   32'd0);
        chk("t4.ready", 32'(load_ready),   32'd1);
        for (int i = 0; i < W; i++) step(1'b0, '0, 1'b0, "t4");

        // Test 5: asynchronous reset during bit 4 with a word held.
        step(1'b1, 8'h55, 1'b1, "t5");
        step(1'b1, 8'h66, 1'b0, "t5");
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, "t5");
        chk("t5.pre_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t5.valid", 32'(serial_valid), 32'd0);
        chk("t5.busy",  32'(busy),         32'd0);
        chk("t5.done",  32'(frame_done),   32'd0);
        chk("t5.ready", 32'(load_ready),   32'd1);
        pos = -1;
        pend.delete();
        @(posedge clk);
        #1;
        chk("t5.rst_ready", 32'(load_ready), 32'd1);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t5.no_residual", 32'(serial_valid), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, "t5post");
        step(1'b1, 8'h81, 1'b0, "t5first");

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom), "rnd");
        end
        for (int n = 0; n < 2*W+2; n++) step(1'b0, '0, 1'b0, "drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
